burst_memory: RTL

//   Synthesizable main-memory responder for the MIPS core and its loader benches.

---
 rtl/burst_memory.sv | 131 +++++++++++++
 1 files changed

// File: rtl/burst_memory.sv
// Word-wide byte-addressed memory responder with single and burst (4/8/16) access.
// Bursts occupy the port for N-1 extra cycles; out-of-range bursts are absorbed silently.
module burst_memory #(
    parameter int unsigned                data_width    = 32,
    parameter int unsigned                address_width = 32,
    parameter int unsigned                depth         = 1048576,
    parameter logic [address_width-1:0]   start_addr    = 'h80020000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [address_width-1:0] address,
    input  logic [data_width-1:0]    data_in,
    input  logic [1:0]               access_size,
    input  logic                     rw,
    input  logic                     enable,
    output logic                     busy,
    output logic [data_width-1:0]    data_out,
    output logic                     addr_error
);

    localparam int unsigned IW    = $clog2(depth) - 2;
    localparam int unsigned WORDS = depth / 4;
    localparam logic [address_width-1:0] DEPTH_A = address_width'(depth);

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    err_q, err_d;
    logic [data_width-1:0]   dout_q, dout_d;

    logic [data_width-1:0]   mem [WORDS];
    logic [data_width-1:0]   mem_rdata;
    logic [IW-1:0]           mem_idx;
    logic                    mem_we;

    logic [address_width-1:0] offset;
    logic                     in_range;
    logic [IW-1:0]            acc_idx;
    logic [3:0]               beats_m1;
    logic                     beat, beat_rd, beat_ok;

    assign offset    = address - start_addr;
    assign in_range  = offset < DEPTH_A;
    assign acc_idx   = offset[IW+1:2];
    assign mem_rdata = mem[mem_idx];

    always_comb begin
        beats_m1 = 4'd0;
        unique case (access_size)
            2'b00: beats_m1 = 4'd0;
            2'b01: beats_m1 = 4'd3;
            2'b10: beats_m1 = 4'd7;
            2'b11: beats_m1 = 4'd15;
            default: beats_m1 = 4'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        dout_d  = dout_q;
        mem_idx = idx_q;
        beat    = 1'b0;
        beat_rd = 1'b0;
        beat_ok = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    beat    = 1'b1;
                    beat_rd = rw;
                    beat_ok = in_range;
                    mem_idx = acc_idx;
                    err_d   = !in_range;
                    idx_d   = acc_idx + IW'(1);
                    cnt_d   = beats_m1;
                    if (beats_m1 != 4'd0)
                        state_d = rw ? RD_BURST : WR_BURST;
                end
            end
            WR_BURST, RD_BURST: begin
                beat    = 1'b1;
                beat_rd = (state_q == RD_BURST);
                beat_ok = !err_q;
                idx_d   = idx_q + IW'(1);
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Out-of-range reads still take a beat but return zero.
        if (beat && beat_rd)
            dout_d = beat_ok ? mem_rdata : '0;
        mem_we = beat && !beat_rd && beat_ok && !reset;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_idx] <= data_in;
    end

    assign busy       = (state_q != IDLE);
    assign data_out   = dout_q;
    assign addr_error = err_q;

endmodule
